// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between the two requesters, the register file write port
// and the issue-side scoreboard query.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              req0_valid;
  logic              req0_ready;
  logic              req0_fp;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req1_valid;
  logic              req1_ready;
  logic              req1_fp;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              rf_write;
  logic              rf_fpoint;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              alloc_valid;
  logic              alloc_fp;
  logic [ADDR_W-1:0] alloc_addr;
  logic              chk_fp;
  logic [ADDR_W-1:0] chk_addr;
  logic              chk_busy;

  modport master (
    output req0_valid, req0_fp, req0_addr, req0_data,
    output req1_valid, req1_fp, req1_addr, req1_data,
    output alloc_valid, alloc_fp, alloc_addr, chk_fp, chk_addr,
    input  req0_ready, req1_ready, rf_write, rf_fpoint, rf_waddr, rf_wdata, chk_busy
  );

  modport slave (
    input  req0_valid, req0_fp, req0_addr, req0_data,
    input  req1_valid, req1_fp, req1_addr, req1_data,
    input  alloc_valid, alloc_fp, alloc_addr, chk_fp, chk_addr,
    output req0_ready, req1_ready, rf_write, rf_fpoint, rf_waddr, rf_wdata, chk_busy
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-requester write-back arbiter for the register file write port, plus a
// per-bank pending-write scoreboard for RAW stall checks.

// One scoreboard bank: busy bit per register, set on alloc, cleared on write.
module regfile_wb_sb_bank #(
  parameter int ADDR_W    = 5,
  parameter int NREGS     = 32,
  parameter bit ZERO_HARD = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              busy
);
  logic [NREGS-1:0] bits_q;

  // Set is checked first so a same-edge alloc keeps the register busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      bits_q <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (set_en && set_addr == ADDR_W'(i) && !(ZERO_HARD && i == 0))
          bits_q[i] <= 1'b1;
        else if (clr_en && clr_addr == ADDR_W'(i))
          bits_q[i] <= 1'b0;
      end
    end
  end

  assign busy = bits_q[rd_addr];
endmodule

module regfile_wb_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREGS    = 32,
  parameter int ARB_MODE = 0
) (
  input logic                 clk,
  input logic                 reset,
  regfile_wb_arbiter_if.slave bus
);
  logic [1:0]        vld;
  logic [1:0]        gnt;
  logic              rr_ptr;
  logic              sel_fp;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              wr_q;
  logic              fp_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        bank_busy;

  assign vld = {bus.req1_valid, bus.req0_valid};

  // Grants depend only on the valids and rr_ptr, never on the other ready.
  always_comb begin
    gnt = '0;
    if (!reset) begin
      gnt[0] = vld[0] && (!vld[1] || ARB_MODE == 1 || !rr_ptr);
      gnt[1] = vld[1] && (!vld[0] || (ARB_MODE == 0 && rr_ptr));
    end
  end

  assign bus.req0_ready = gnt[0];
  assign bus.req1_ready = gnt[1];

  always_comb begin
    sel_fp   = bus.req0_fp;
    sel_addr = bus.req0_addr;
    sel_data = bus.req0_data;
    if (gnt[1]) begin
      sel_fp   = bus.req1_fp;
      sel_addr = bus.req1_addr;
      sel_data = bus.req1_data;
    end
  end

  // Int r0 is hardwired zero: the grant is consumed but no write is issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= 1'b0;
      fp_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      rr_ptr  <= 1'b0;
    end else begin
      wr_q <= (|gnt) && (sel_fp || sel_addr != '0);
      if (|gnt) begin
        fp_q    <= sel_fp;
        waddr_q <= sel_addr;
        wdata_q <= sel_data;
        rr_ptr  <= gnt[0];
      end
    end
  end

  assign bus.rf_write  = wr_q;
  assign bus.rf_fpoint = fp_q;
  assign bus.rf_waddr  = waddr_q;
  assign bus.rf_wdata  = wdata_q;

  // Bank 0 = int (r0 never tracked), bank 1 = fp.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic bank_sel_alloc;
    logic bank_sel_wr;
    assign bank_sel_alloc = (b == 1) ? bus.alloc_fp : !bus.alloc_fp;
    assign bank_sel_wr    = (b == 1) ? fp_q : !fp_q;

    regfile_wb_sb_bank #(
      .ADDR_W   (ADDR_W),
      .NREGS    (NREGS),
      .ZERO_HARD(b == 0)
    ) u_bank (
      .clk     (clk),
      .reset   (reset),
      .set_en  (bus.alloc_valid && bank_sel_alloc),
      .set_addr(bus.alloc_addr),
      .clr_en  (wr_q && bank_sel_wr),
      .clr_addr(waddr_q),
      .rd_addr (bus.chk_addr),
      .busy    (bank_busy[b])
    );
  end

  assign bus.chk_busy = bank_busy[bus.chk_fp];
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios and random traffic on a
// round-robin and a fixed-priority instance, checked against a cycle model.
module tb_regfile_wb_arbiter;
  localparam int NREGS = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Stimulus and observed outputs, indexed [dut][requester]; dut 0 = RR, 1 = fixed.
  logic        v   [2][2];
  logic        rfp [2][2];
  logic [4:0]  ra  [2][2];
  logic [31:0] rd  [2][2];
  logic        al_v[2], al_fp[2], ck_fp[2];
  logic [4:0]  al_a[2], ck_a[2];
  logic        rdy [2][2];
  logic        wr[2], wfp[2], busy[2];
  logic [4:0]  wa[2];
  logic [31:0] wd[2];

  for (genvar d = 0; d < 2; d++) begin : g_dut
    regfile_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();
    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .NREGS(NREGS), .ARB_MODE(d)) u_dut (
      .clk(clk), .reset(reset), .bus(bus)
    );
    assign bus.req0_valid  = v[d][0];
    assign bus.req0_fp     = rfp[d][0];
    assign bus.req0_addr   = ra[d][0];
    assign bus.req0_data   = rd[d][0];
    assign bus.req1_valid  = v[d][1];
    assign bus.req1_fp     = rfp[d][1];
    assign bus.req1_addr   = ra[d][1];
    assign bus.req1_data   = rd[d][1];
    assign bus.alloc_valid = al_v[d];
    assign bus.alloc_fp    = al_fp[d];
    assign bus.alloc_addr  = al_a[d];
    assign bus.chk_fp      = ck_fp[d];
    assign bus.chk_addr    = ck_a[d];
    assign rdy[d][0] = bus.req0_ready;
    assign rdy[d][1] = bus.req1_ready;
    assign wr[d]     = bus.rf_write;
    assign wfp[d]    = bus.rf_fpoint;
    assign wa[d]     = bus.rf_waddr;
    assign wd[d]     = bus.rf_wdata;
    assign busy[d]   = bus.chk_busy;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Reference model state.
  bit        m_rr  [2];
  bit        m_busy[2][2][NREGS];
  bit        m_wr[2], m_fp[2];
  bit [4:0]  m_a[2];
  bit [31:0] m_d[2];
  int        win[2];

  // Check one cycle against the model, clock it, then advance the model.
  task automatic step();
    #1;
    for (int d = 0; d < 2; d++) begin
      win[d] = -1;
      if (!reset) begin
        if (v[d][0] && v[d][1]) win[d] = (d == 1) ? 0 : int'(m_rr[d]);
        else if (v[d][0])       win[d] = 0;
        else if (v[d][1])       win[d] = 1;
      end
      check($sformatf("d%0d_ready0", d), rdy[d][0], win[d] == 0);
      check($sformatf("d%0d_ready1", d), rdy[d][1], win[d] == 1);
      check($sformatf("d%0d_chk_busy", d), busy[d], m_busy[d][ck_fp[d]][ck_a[d]]);
      check($sformatf("d%0d_rf_write", d), wr[d], m_wr[d]);
      check($sformatf("d%0d_rf_fpoint", d), wfp[d], m_fp[d]);
      check($sformatf("d%0d_rf_waddr", d), wa[d], m_a[d]);
      check($sformatf("d%0d_rf_wdata", d), wd[d], m_d[d]);
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        m_rr[d] = 0; m_wr[d] = 0; m_fp[d] = 0; m_a[d] = '0; m_d[d] = '0;
        for (int b = 0; b < 2; b++)
          for (int r = 0; r < NREGS; r++) m_busy[d][b][r] = 0;
      end else begin
        if (m_wr[d]) m_busy[d][m_fp[d]][m_a[d]] = 0;
        if (al_v[d] && (al_fp[d] || al_a[d] != 0)) m_busy[d][al_fp[d]][al_a[d]] = 1;
        m_wr[d] = 0;
        if (win[d] >= 0) begin
          m_wr[d] = rfp[d][win[d]] || ra[d][win[d]] != 0;
          m_fp[d] = rfp[d][win[d]];
          m_a[d]  = ra[d][win[d]];
          m_d[d]  = rd[d][win[d]];
          m_rr[d] = (win[d] == 0);
          v[d][win[d]] = 1'b0;
        end
      end
    end
  endtask

  task automatic req(input int d, input int r, input logic fp, input logic [4:0] a,
                     input logic [31:0] data);
    v[d][r] = 1'b1; rfp[d][r] = fp; ra[d][r] = a; rd[d][r] = data;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 2; r++) begin
        v[d][r] = 0; rfp[d][r] = 0; ra[d][r] = '0; rd[d][r] = '0;
      end
      al_v[d] = 0; al_fp[d] = 0; al_a[d] = '0; ck_fp[d] = 0; ck_a[d] = '0;
    end
    reset = 1'b1;
    step(); step();
    reset = 1'b0;

    // Single requester, granted the same cycle, written the next.
    req(0, 0, 1'b0, 5'd5, 32'hDEADBEEF);
    #1 check("t1_ready", rdy[0][0], 1);
    step();
    check("t1_write", wr[0], 1);
    check("t1_fpoint", wfp[0], 0);
    check("t1_waddr", wa[0], 5);
    check("t1_wdata", wd[0], 32'hDEADBEEF);

    // Round-robin alternation starting from reset.
    reset = 1'b1; step(); reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!v[0][0]) req(0, 0, 1'b0, 5'(i + 1), 32'h100 + i);
      if (!v[0][1]) req(0, 1, 1'b1, 5'(i + 10), 32'h200 + i);
      #1;
      check("t2_ready0", rdy[0][0], (i % 2) == 0);
      check("t2_ready1", rdy[0][1], (i % 2) == 1);
      step();
    end
    v[0][0] = 0;
    step();

    // Fixed priority: req0 wins every contended cycle.
    for (int i = 0; i < 3; i++) begin
      if (!v[1][0]) req(1, 0, 1'b0, 5'(i + 3), 32'h300 + i);
      if (!v[1][1]) req(1, 1, 1'b0, 5'd9, 32'h399);
      #1;
      check("t3_ready0", rdy[1][0], 1);
      check("t3_ready1", rdy[1][1], 0);
      step();
    end
    step();

    // Int r0 is accepted but not written; fp r0 is written.
    req(0, 1, 1'b0, 5'd0, 32'h1234);
    #1 check("t4_ready_int0", rdy[0][1], 1);
    step();
    check("t4_write_int0", wr[0], 0);
    req(0, 1, 1'b1, 5'd0, 32'h1234);
    step();
    check("t4_write_fp0", wr[0], 1);
    check("t4_fpoint_fp0", wfp[0], 1);

    // Scoreboard set, bank separation, clear, and set-wins collision.
    al_v[0] = 1; al_fp[0] = 1; al_a[0] = 5'd7;
    step();
    al_v[0] = 0;
    ck_fp[0] = 1; ck_a[0] = 5'd7;
    #1 check("t5_busy_fp7", busy[0], 1);
    ck_fp[0] = 0;
    #1 check("t5_busy_int7", busy[0], 0);
    ck_fp[0] = 1;
    req(0, 0, 1'b1, 5'd7, 32'h77);
    step();
    step();
    #1 check("t5_cleared", busy[0], 0);
    al_v[0] = 1;
    step();
    al_v[0] = 0;
    req(0, 0, 1'b1, 5'd7, 32'h78);
    step();
    al_v[0] = 1;
    #1 check("t5_collide_write", wr[0], 1);
    step();
    al_v[0] = 0;
    #1 check("t5_set_wins", busy[0], 1);

    // Reset with traffic pending and registers busy.
    al_v[0] = 1; al_fp[0] = 0; al_a[0] = 5'd3; step();
    al_fp[0] = 1; al_a[0] = 5'd9; step();
    al_fp[0] = 0; al_a[0] = 5'd20; step();
    al_v[0] = 0;
    req(0, 0, 1'b0, 5'd11, 32'hAAAA);
    req(0, 1, 1'b0, 5'd12, 32'hBBBB);
    reset = 1'b1;
    #1;
    check("t6_rst_ready0", rdy[0][0], 0);
    check("t6_rst_ready1", rdy[0][1], 0);
    step(); step();
    reset = 1'b0;
    check("t6_write_after", wr[0], 0);
    ck_fp[0] = 0; ck_a[0] = 5'd3;  #1 check("t6_busy_i3", busy[0], 0);
    ck_fp[0] = 1; ck_a[0] = 5'd9;  #1 check("t6_busy_f9", busy[0], 0);
    ck_fp[0] = 0; ck_a[0] = 5'd20; #1 check("t6_busy_i20", busy[0], 0);
    check("t6_first_ready0", rdy[0][0], 1);
    check("t6_first_ready1", rdy[0][1], 0);
    step();

    // Random traffic on both instances.
    for (int it = 0; it < 1500; it++) begin
      for (int d = 0; d < 2; d++) begin
        for (int r = 0; r < 2; r++)
          if (!v[d][r] && $urandom_range(0, 9) < 6)
            req(d, r, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)), $urandom);
        al_v[d]  = ($urandom_range(0, 3) == 0);
        al_fp[d] = 1'($urandom_range(0, 1));
        al_a[d]  = 5'($urandom_range(0, 15));
        ck_fp[d] = 1'($urandom_range(0, 1));
        ck_a[d]  = 5'($urandom_range(0, 15));
      end
      reset = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
